// File: rtl/multicycle_ctrl_seq_if.sv
// Fetch/decode and data-memory signals seen by the sequencer.
// master = fetch/decoder/memory side, slave = sequencer side.
interface multicycle_ctrl_seq_if;
  logic       instr_valid;
  logic       instr_ready;
  logic [4:0] opcode;
  logic       dec_halt;
  logic       dec_reg_write;
  logic       dec_mem_write;
  logic       dec_sel_wb;
  logic       dec_branch;
  logic       dec_jump;
  logic       br_taken;
  logic       mem_req;
  logic       mem_we;
  logic       mem_ack;

  modport master (
    output instr_valid,
    output opcode,
    output dec_halt,
    output dec_reg_write,
    output dec_mem_write,
    output dec_sel_wb,
    output dec_branch,
    output dec_jump,
    output br_taken,
    output mem_ack,
    input  instr_ready,
    input  mem_req,
    input  mem_we
  );

  modport slave (
    input  instr_valid,
    input  opcode,
    input  dec_halt,
    input  dec_reg_write,
    input  dec_mem_write,
    input  dec_sel_wb,
    input  dec_branch,
    input  dec_jump,
    input  br_taken,
    input  mem_ack,
    output instr_ready,
    output mem_req,
    output mem_we
  );
endinterface

// File: rtl/multicycle_ctrl_seq.sv
// Multi-cycle EXEC/MEM/WB sequencer with halt latch and memory-timeout trap.
// Optional performance counters: define MCSEQ_PERF_CNT_EN.
module multicycle_ctrl_seq #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_ctrl_seq_if.slave bus,
  output logic                 alu_en,
  output logic                 rf_we,
  output logic                 pc_we,
  output logic                 pc_sel_branch,
  output logic [4:0]           cur_opcode,
  output logic                 halted,
  output logic                 err,
  output logic [CNT_W-1:0]     retired_cnt,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam int WAIT_W =
    (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM =
    WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT,
    S_ERR
  } state_t;

  state_t state;

  logic [4:0]        op_q;
  logic              rw_q;
  logic              mw_q;
  logic              ld_q;
  logic              br_q;
  logic              jmp_q;
  logic [WAIT_W-1:0] wait_q;

  logic ready_q;
  logic alu_q;
  logic req_q;
  logic we_q;
  logic rf_q;
  logic ret_q;
  logic halt_q;
  logic err_q;

  logic acc_mem;
  logic acc_none;
  logic ex_mem;

  assign acc_mem  = bus.dec_sel_wb | bus.dec_mem_write;
  assign acc_none = ~acc_mem & ~bus.dec_reg_write;
  assign ex_mem   = ld_q | mw_q;

  // Sequencer FSM; every Moore output is registered alongside the
  // state so it is valid in the first cycle of the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      op_q    <= '0;
      rw_q    <= 1'b0;
      mw_q    <= 1'b0;
      ld_q    <= 1'b0;
      br_q    <= 1'b0;
      jmp_q   <= 1'b0;
      wait_q  <= '0;
      ready_q <= 1'b1;
      alu_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      rf_q    <= 1'b0;
      ret_q   <= 1'b0;
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      alu_q <= 1'b0;
      rf_q  <= 1'b0;
      ret_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.instr_valid) begin
            op_q    <= bus.opcode;
            rw_q    <= bus.dec_reg_write;
            mw_q    <= bus.dec_mem_write;
            ld_q    <= bus.dec_sel_wb;
            br_q    <= bus.dec_branch;
            jmp_q   <= bus.dec_jump;
            ready_q <= 1'b0;
            if (bus.dec_halt) begin
              state  <= S_HALT;
              halt_q <= 1'b1;
            end else begin
              state <= S_EXEC;
              alu_q <= 1'b1;
              ret_q <= acc_none;
            end
          end
        end
        S_EXEC: begin
          if (ex_mem) begin
            state  <= S_MEM;
            req_q  <= 1'b1;
            we_q   <= mw_q;
            wait_q <= '0;
          end else if (rw_q) begin
            state <= S_WB;
            rf_q  <= 1'b1;
          end else begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
          end
        end
        S_MEM: begin
          if (bus.mem_ack) begin
            req_q <= 1'b0;
            we_q  <= 1'b0;
            if (ld_q) begin
              state <= S_WB;
              rf_q  <= 1'b1;
            end else begin
              state   <= S_IDLE;
              ready_q <= 1'b1;
            end
          end else if (MEM_TIMEOUT != 0 &&
                       wait_q == WAIT_LIM) begin
            state <= S_ERR;
            req_q <= 1'b0;
            we_q  <= 1'b0;
            err_q <= 1'b1;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        S_WB: begin
          state   <= S_IDLE;
          ready_q <= 1'b1;
        end
        S_HALT: begin
          state <= S_HALT;
        end
        S_ERR: begin
          state <= S_ERR;
        end
        default: begin
          state   <= S_IDLE;
          ready_q <= 1'b1;
          req_q   <= 1'b0;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.instr_ready = ready_q;
  assign bus.mem_req     = req_q;
  assign bus.mem_we      = we_q;
  assign alu_en          = alu_q;
  assign rf_we           = rf_q;
  assign cur_opcode      = op_q;
  assign halted          = halt_q;
  assign err             = err_q;

  // Stores retire in the ack cycle itself, hence the mem_ack term.
  assign pc_we = ret_q | rf_q |
                 (req_q & bus.mem_ack & ~ld_q);

  // Target select only matters for EXEC-retired control flow.
  assign pc_sel_branch = ret_q &
                         (jmp_q | (br_q & bus.br_taken));

`ifdef MCSEQ_PERF_CNT_EN
  logic [CNT_W-1:0] ret_cnt_q;
  logic [CNT_W-1:0] stl_cnt_q;
  logic             stall_cyc;

  assign stall_cyc = req_q & ~bus.mem_ack;

  // Saturating retire and memory-stall counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ret_cnt_q <= '0;
      stl_cnt_q <= '0;
    end else begin
      if (pc_we && ret_cnt_q != '1)
        ret_cnt_q <= ret_cnt_q + CNT_W'(1);
      if (stall_cyc && stl_cnt_q != '1)
        stl_cnt_q <= stl_cnt_q + CNT_W'(1);
    end
  end

  assign retired_cnt = ret_cnt_q;
  assign stall_cnt   = stl_cnt_q;
`else
  assign retired_cnt = '0;
  assign stall_cnt   = '0;
`endif

endmodule
